oam_dma_ctrl: RTL and testbench

- Sprite-DMA sequencer for the CPU bus. It snoops CPU writes to the DMA trigger register, halts the CPU and takes ownership of the address/data/r_nw bus. It then copies XFER_LEN bytes from page {page,idx} to the PPU OAM data port, alternating one READ cycle and one WRITE cycle per byte.
- It sits between rp2a03 and the top-level bus mux. When active_out=1, the top level selects this block's a_out/d_out/r_nw_out in place of the CPU's.

---
 rtl/oam_dma_if.sv | 30 +++
 rtl/oam_dma_ctrl.sv | 126 ++++++++++++
 tb/tb_oam_dma_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_if.sv
// CPU-bus snoop inputs and DMA bus-master outputs of the sprite-DMA sequencer.
// master = the DMA block, slave = the top-level bus mux / test environment.
interface oam_dma_if;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;

    logic [AW-1:0] cpu_a_in;
    logic          cpu_r_nw_in;
    logic [DW-1:0] cpu_d_in;
    logic [DW-1:0] mem_d_in;
    logic          rdy_in;

    logic          active_out;
    logic          cpu_rdy_out;
    logic [AW-1:0] a_out;
    logic [DW-1:0] d_out;
    logic          r_nw_out;
    logic          done_out;
    logic [DW-1:0] dbg_data;

    modport master (
        input  cpu_a_in, cpu_r_nw_in, cpu_d_in, mem_d_in, rdy_in,
        output active_out, cpu_rdy_out, a_out, d_out, r_nw_out, done_out, dbg_data
    );

    modport slave (
        output cpu_a_in, cpu_r_nw_in, cpu_d_in, mem_d_in, rdy_in,
        input  active_out, cpu_rdy_out, a_out, d_out, r_nw_out, done_out, dbg_data
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA sequencer: halts the CPU and copies XFER_LEN bytes from {page,idx} to OAMDATA.
// Optional macro OAM_DMA_ALIGN_EN inserts an ALIGN cycle when the transfer starts on an odd cycle.
module oam_dma_ctrl #(
    parameter logic [15:0] TRIG_ADDR = 16'h4014,
    parameter logic [15:0] DST_ADDR  = 16'h2004,
    parameter int unsigned XFER_LEN  = 256
) (
    input  logic      clk_in,
    input  logic      rst_in,
    oam_dma_if.master bus
);
    localparam int unsigned IDX_W = 8;
    localparam int unsigned DW    = 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DW-1:0]    page;
    logic [DW-1:0]    page_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic             done_q;
    logic             done_nxt;
    logic [DW-1:0]    data_q;
    logic             trig_c;

    assign trig_c = (bus.cpu_a_in == TRIG_ADDR) && !bus.cpu_r_nw_in;

`ifdef OAM_DMA_ALIGN_EN
    // Free-running get/put phase; even = 0 out of reset.
    logic parity;

    always_ff @(posedge clk_in) begin
        if (rst_in) parity <= 1'b0;
        else        parity <= ~parity;
    end
`endif

    // State and datapath registers; reset wins over a simultaneous trigger.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state  <= IDLE;
            page   <= '0;
            idx    <= '0;
            done_q <= 1'b0;
            data_q <= '0;
        end else begin
            state  <= state_nxt;
            page   <= page_nxt;
            idx    <= idx_nxt;
            done_q <= done_nxt;
            if (state == WRITE) data_q <= bus.mem_d_in;
        end
    end

    // Next-state and bus outputs decoded from the current state.
    always_comb begin
        state_nxt       = state;
        page_nxt        = page;
        idx_nxt         = idx;
        done_nxt        = 1'b0;
        bus.active_out  = 1'b0;
        bus.cpu_rdy_out = 1'b1;
        bus.a_out       = '0;
        bus.d_out       = '0;
        bus.r_nw_out    = 1'b1;

        case (state)
            IDLE: begin
                if (trig_c) begin
                    page_nxt  = bus.cpu_d_in;
                    idx_nxt   = '0;
                    state_nxt = HALT;
                end
            end
            HALT: begin
                bus.active_out  = 1'b1;
                bus.cpu_rdy_out = 1'b0;
                bus.a_out       = bus.cpu_a_in;
                state_nxt       = READ;
`ifdef OAM_DMA_ALIGN_EN
                if (parity) state_nxt = ALIGN;
`endif
            end
            ALIGN: begin
                bus.active_out  = 1'b1;
                bus.cpu_rdy_out = 1'b0;
                bus.a_out       = bus.cpu_a_in;
                state_nxt       = READ;
            end
            READ: begin
                bus.active_out  = 1'b1;
                bus.cpu_rdy_out = 1'b0;
                bus.a_out       = {page, idx};
                if (bus.rdy_in) state_nxt = WRITE;
            end
            WRITE: begin
                // Synchronous read data arrives now, so it is forwarded straight to the bus.
                bus.active_out  = 1'b1;
                bus.cpu_rdy_out = 1'b0;
                bus.a_out       = DST_ADDR;
                bus.r_nw_out    = 1'b0;
                bus.d_out       = bus.mem_d_in;
                if (idx == LAST_IDX) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    idx_nxt   = idx + IDX_W'(1);
                    state_nxt = READ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.done_out = done_q;
    assign bus.dbg_data = data_q;
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: a 256-byte instance and a 4-byte instance share one WRAM/OAM model.
module tb_oam_dma_ctrl;
    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic        rst;
    logic        sel;
    logic [15:0] cpu_a;
    logic        cpu_r_nw;
    logic [7:0]  cpu_d;
    logic        rdy;
    logic [7:0]  mem_q;

    oam_dma_if bus0 ();
    oam_dma_if bus1 ();

    oam_dma_ctrl u_dut0 (.clk_in(clk), .rst_in(rst), .bus(bus0.master));
    oam_dma_ctrl #(.XFER_LEN(4)) u_dut1 (.clk_in(clk), .rst_in(rst), .bus(bus1.master));

    // Only the selected instance sees the CPU; the other one sits on a quiet bus.
    assign bus0.cpu_a_in    = sel ? 16'h8000 : cpu_a;
    assign bus0.cpu_r_nw_in = sel ? 1'b1 : cpu_r_nw;
    assign bus0.cpu_d_in    = cpu_d;
    assign bus0.mem_d_in    = mem_q;
    assign bus0.rdy_in      = rdy;
    assign bus1.cpu_a_in    = sel ? cpu_a : 16'h8000;
    assign bus1.cpu_r_nw_in = sel ? cpu_r_nw : 1'b1;
    assign bus1.cpu_d_in    = cpu_d;
    assign bus1.mem_d_in    = mem_q;
    assign bus1.rdy_in      = rdy;

    wire        o_active  = sel ? bus1.active_out  : bus0.active_out;
    wire        o_cpu_rdy = sel ? bus1.cpu_rdy_out : bus0.cpu_rdy_out;
    wire [15:0] o_a       = sel ? bus1.a_out       : bus0.a_out;
    wire [7:0]  o_d       = sel ? bus1.d_out       : bus0.d_out;
    wire        o_r_nw    = sel ? bus1.r_nw_out    : bus0.r_nw_out;
    wire        o_done    = sel ? bus1.done_out    : bus0.done_out;
    wire [7:0]  o_dbg     = sel ? bus1.dbg_data    : bus0.dbg_data;

    logic [7:0] wram [0:65535];
    logic [7:0] oam  [0:4095];
    int         oam_ptr = 0;

    // Synchronous memory: data valid the cycle after the address.
    always @(posedge clk) mem_q <= wram[o_a];

    // OAM port: every bus write to OAMDATA lands at the next free slot.
    always @(posedge clk) begin
        if (o_active && !o_r_nw && o_a == 16'h2004) begin
            oam[oam_ptr] <= o_d;
            oam_ptr      <= oam_ptr + 1;
        end
    end

`ifdef OAM_DMA_ALIGN_EN
    logic tb_par;
    always @(posedge clk) tb_par <= rst ? 1'b0 : ~tb_par;
`endif

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic       sel;
        logic [7:0] page;
        int         stall_idx;
        int         stall_len;
        int         retrig_idx;
        int         rst_idx;
        int         pre_idle;
        int         exp_cycles;
        int         exp_writes;
    } vec_t;

    task automatic run(input vec_t v);
        int         len;
        int         cyc;
        int         idx;
        int         stalls;
        int         ptr0;
        int         seq_err;
        int         aligns;
        int         exp_align;
        int         bad;
        bit         wr_phase;
        bit         retrig_done;
        bit         did_rst;
        logic [15:0] s_a;
        logic [7:0]  s_d;
        logic        s_r_nw;
        logic        s_act;

        len = v.sel ? 4 : 256;
        sel = v.sel;
        repeat (v.pre_idle) @(negedge clk);
        @(negedge clk);
        ptr0     = oam_ptr;
        cpu_a    = 16'h4014;
        cpu_r_nw = 1'b0;
        cpu_d    = v.page;
        rdy      = 1'b1;
        @(negedge clk);
        // HALT: bus shows the CPU address while the CPU is held
        chk("halt_active", 32'(o_active), 32'd1);
        chk("halt_cpu_rdy", 32'(o_cpu_rdy), 32'd0);
        chk("halt_addr", 32'(o_a), 32'(cpu_a));
        exp_align = 0;
`ifdef OAM_DMA_ALIGN_EN
        exp_align = int'(tb_par);
`endif
        cpu_a = 16'h8000; cpu_r_nw = 1'b1;
        cyc = 1; idx = 0; stalls = 0; seq_err = 0; aligns = 0;
        wr_phase = 1'b0; retrig_done = 1'b0; did_rst = 1'b0;
        @(negedge clk);
        while (o_cpu_rdy === 1'b0 && cyc < 2000) begin
            cyc++;
            s_a = o_a; s_d = o_d; s_r_nw = o_r_nw; s_act = o_active;
            cpu_a = 16'h8000; cpu_r_nw = 1'b1; rdy = 1'b1;
            if (cyc == 2 && s_a == 16'h8000 && s_r_nw) begin
                aligns++;
            end else if (!wr_phase) begin
                if (s_a !== {v.page, 8'(idx)} || s_r_nw !== 1'b1 || s_act !== 1'b1) begin
                    if (seq_err == 0) $display("read idx %0h: a=%0h r_nw=%0b", idx, s_a, s_r_nw);
                    seq_err++;
                end
                if (idx == v.retrig_idx && !retrig_done) begin
                    cpu_a = 16'h4014; cpu_r_nw = 1'b0; cpu_d = 8'h07;
                    retrig_done = 1'b1;
                end
                if (idx == v.stall_idx && stalls < v.stall_len) begin
                    rdy = 1'b0;
                    stalls++;
                end else begin
                    wr_phase = 1'b1;
                end
            end else begin
                if (s_a !== 16'h2004 || s_r_nw !== 1'b0 || s_d !== wram[{v.page, 8'(idx)}]) begin
                    if (seq_err == 0) $display("write idx %0h: a=%0h r_nw=%0b d=%0h", idx, s_a, s_r_nw, s_d);
                    seq_err++;
                end
                if (idx == v.rst_idx) begin
                    rst = 1'b1;
                    did_rst = 1'b1;
                end
                idx++;
                wr_phase = 1'b0;
            end
            @(negedge clk);
        end
        chk("cycles", 32'(cyc), 32'(v.exp_cycles + exp_align));
        chk("aligns", 32'(aligns), 32'(exp_align));
        chk("seq_errors", 32'(seq_err), 32'd0);
        chk("end_active", 32'(o_active), 32'd0);
        chk("end_r_nw", 32'(o_r_nw), 32'd1);
        chk("end_addr", 32'(o_a), 32'd0);
        chk("done_pulse", 32'(o_done), did_rst ? 32'd0 : 32'd1);
        if (!did_rst) chk("dbg_data", 32'(o_dbg), 32'(wram[{v.page, 8'(len - 1)}]));
        rst = 1'b0;
        @(negedge clk);
        chk("done_clear", 32'(o_done), 32'd0);
        chk("oam_writes", 32'(oam_ptr - ptr0), 32'(v.exp_writes));
        bad = 0;
        for (int i = 0; i < v.exp_writes; i++)
            if (oam[ptr0 + i] !== wram[{v.page, 8'(i)}]) bad++;
        chk("oam_data", 32'(bad), 32'd0);
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{sel:1'b0, page:8'h02, stall_idx:-1,    stall_len:0, retrig_idx:-1,    rst_idx:-1,    pre_idle:0, exp_cycles:513, exp_writes:256};
        vecs[1] = '{sel:1'b0, page:8'h02, stall_idx:'h10,  stall_len:5, retrig_idx:-1,    rst_idx:-1,    pre_idle:1, exp_cycles:518, exp_writes:256};
        vecs[2] = '{sel:1'b0, page:8'h02, stall_idx:-1,    stall_len:0, retrig_idx:'h40,  rst_idx:-1,    pre_idle:0, exp_cycles:513, exp_writes:256};
        vecs[3] = '{sel:1'b0, page:8'h02, stall_idx:-1,    stall_len:0, retrig_idx:-1,    rst_idx:'h80,  pre_idle:1, exp_cycles:259, exp_writes:129};
        vecs[4] = '{sel:1'b0, page:8'h31, stall_idx:-1,    stall_len:0, retrig_idx:-1,    rst_idx:-1,    pre_idle:0, exp_cycles:513, exp_writes:256};
        vecs[5] = '{sel:1'b1, page:8'hFF, stall_idx:-1,    stall_len:0, retrig_idx:-1,    rst_idx:-1,    pre_idle:0, exp_cycles:9,   exp_writes:4};
        vecs[6] = '{sel:1'b1, page:8'h03, stall_idx:-1,    stall_len:0, retrig_idx:-1,    rst_idx:-1,    pre_idle:1, exp_cycles:9,   exp_writes:4};

        for (int i = 0; i < 65536; i++) wram[i] = 8'((i * 13) ^ (i >> 8));

        // Reset with a trigger present: the trigger must be ignored.
        sel = 1'b0; rst = 1'b1; rdy = 1'b1;
        cpu_a = 16'h4014; cpu_r_nw = 1'b0; cpu_d = 8'h55;
        repeat (3) @(negedge clk);
        chk("rst_active", 32'(o_active), 32'd0);
        chk("rst_cpu_rdy", 32'(o_cpu_rdy), 32'd1);
        chk("rst_addr", 32'(o_a), 32'd0);
        chk("rst_data", 32'(o_d), 32'd0);
        chk("rst_r_nw", 32'(o_r_nw), 32'd1);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_active_small", 32'(bus1.active_out), 32'd0);
        cpu_a = 16'h8000; cpu_r_nw = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_active", 32'(o_active), 32'd0);

        for (int i = 0; i < 7; i++) run(vecs[i]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
